// File: rtl/isq_inorder_mw.sv
// rtl/isq_inorder_mw.sv - in-order multi-wakeup issue queue with 2-lane enqueue; optional macro ISQ_UPD_BYPASS_EN
module isq_inorder_mw #(
    parameter int DEPTH       = 8,
    parameter int DEPTH_LOG   = 3,
    parameter int DATA_WIDTH  = 248,
    parameter int COND_WIDTH  = 2,
    parameter int ROBID_WIDTH = 7,
    parameter int NUM_WB      = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [1:0]                    enq_valid,
    output logic                          enq_ready,
    input  logic [2*DATA_WIDTH-1:0]       enq_data,
    input  logic [2*COND_WIDTH-1:0]       enq_cond,
    input  logic [2*ROBID_WIDTH-1:0]      enq_robid,
    output logic                          deq_valid,
    input  logic                          deq_ready,
    output logic [DATA_WIDTH-1:0]         deq_data,
    output logic [COND_WIDTH-1:0]         deq_cond,
    output logic [ROBID_WIDTH-1:0]        deq_robid,
    input  logic                          flush_valid,
    input  logic [ROBID_WIDTH-1:0]        flush_robid,
    input  logic [NUM_WB-1:0]             upd_valid,
    input  logic [NUM_WB*ROBID_WIDTH-1:0] upd_robid,
    input  logic [NUM_WB*COND_WIDTH-1:0]  upd_mask,
    input  logic [NUM_WB*COND_WIDTH-1:0]  upd_data,
    output logic [DEPTH_LOG:0]            count
);

    localparam int CW = COND_WIDTH;
    localparam int RW = ROBID_WIDTH;
    localparam int DW = DATA_WIDTH;
    // Two free slots are needed so a dual-lane enqueue can always land
    localparam logic [DEPTH_LOG:0] ENQ_MAX_COUNT = (DEPTH_LOG+1)'(DEPTH - 2);

    logic [DW-1:0]        data_q  [DEPTH];
    logic [CW-1:0]        cond_q  [DEPTH];
    logic [RW-1:0]        robid_q [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH_LOG-1:0] head;
    logic [DEPTH_LOG-1:0] tail;
    logic [DEPTH_LOG-1:0] tail_p1;

    logic                 acc0;
    logic                 acc1;
    logic [DEPTH_LOG:0]   acc_num;
    logic                 deq_fire;
    logic [CW-1:0]        cond_upd   [DEPTH];
    logic [CW-1:0]        enq_cond_w [2];
    logic [DEPTH-1:0]     kill;
    logic [DEPTH_LOG:0]   survivors;
    logic                 kill_ok;

    // Apply all update ports to one condition vector; the lowest port is applied last so it wins conflicts
    function automatic logic [CW-1:0] apply_upd(
        input logic [CW-1:0]           c,
        input logic [RW-1:0]           id,
        input logic [NUM_WB-1:0]       uv,
        input logic [NUM_WB*RW-1:0]    ur,
        input logic [NUM_WB*CW-1:0]    um,
        input logic [NUM_WB*CW-1:0]    ud
    );
        logic [CW-1:0] r;
        r = c;
        for (int p = NUM_WB - 1; p >= 0; p--) begin
            if (uv[p] && (ur[p*RW +: RW] == id)) begin
                r = (r & ~um[p*CW +: CW]) | (ud[p*CW +: CW] & um[p*CW +: CW]);
            end
        end
        return r;
    endfunction

    // ROB age compare: wrap bit mismatch inverts the sense of the index compare
    function automatic logic is_younger(input logic [RW-1:0] e, input logic [RW-1:0] f);
        return (e[RW-1] ^ f[RW-1]) ^ (e[RW-2:0] > f[RW-2:0]);
    endfunction

    assign enq_ready = (count <= ENQ_MAX_COUNT) && !flush_valid;
    assign acc0      = enq_valid[0] && enq_ready;
    assign acc1      = enq_valid[1] && acc0;
    assign acc_num   = (DEPTH_LOG+1)'(acc0) + (DEPTH_LOG+1)'(acc1);
    assign tail_p1   = tail + DEPTH_LOG'(1);

    assign deq_valid = (count != '0) && valid_q[head] && (&cond_q[head]);
    assign deq_fire  = deq_valid && deq_ready && !flush_valid;
    assign deq_data  = data_q[head];
    assign deq_cond  = cond_q[head];
    assign deq_robid = robid_q[head];

    // Wakeup: merge every update port into each occupied entry's condition bits
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            cond_upd[e] = cond_q[e];
            if (valid_q[e]) begin
                cond_upd[e] = apply_upd(cond_q[e], robid_q[e], upd_valid, upd_robid, upd_mask, upd_data);
            end
        end
    end

    // Condition bits written for entering entries, optionally merged with same-cycle updates
    always_comb begin
        for (int l = 0; l < 2; l++) begin
`ifdef ISQ_UPD_BYPASS_EN
            enq_cond_w[l] = apply_upd(enq_cond[l*CW +: CW], enq_robid[l*RW +: RW],
                                      upd_valid, upd_robid, upd_mask, upd_data);
`else
            enq_cond_w[l] = enq_cond[l*CW +: CW];
`endif
        end
    end

    // Flush scan from head: mark younger entries, count survivors, detect a survivor after a kill
    always_comb begin
        kill      = '0;
        survivors = '0;
        kill_ok   = 1'b1;
        begin
            logic seen_kill;
            logic [DEPTH_LOG-1:0] slot;
            seen_kill = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slot = head + DEPTH_LOG'(i);
                if ((DEPTH_LOG+1)'(i) < count) begin
                    if (is_younger(robid_q[slot], flush_robid)) begin
                        kill[slot] = 1'b1;
                        seen_kill  = 1'b1;
                    end else begin
                        survivors = survivors + (DEPTH_LOG+1)'(1);
                        if (seen_kill) begin
                            kill_ok = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Pointers, occupancy and valid bits; flush takes priority and blocks both handshakes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else if (flush_valid) begin
            valid_q <= valid_q & ~kill;
            tail    <= head + survivors[DEPTH_LOG-1:0];
            count   <= survivors;
        end else begin
            if (deq_fire) begin
                valid_q[head] <= 1'b0;
                head          <= head + DEPTH_LOG'(1);
            end
            if (acc0) begin
                valid_q[tail] <= 1'b1;
            end
            if (acc1) begin
                valid_q[tail_p1] <= 1'b1;
            end
            tail  <= tail + acc_num[DEPTH_LOG-1:0];
            count <= count + acc_num - (DEPTH_LOG+1)'(deq_fire);
        end
    end

    // Entry payload and condition storage; enqueue slots are always free so they never collide with wakeups
    always_ff @(posedge clock) begin
        for (int e = 0; e < DEPTH; e++) begin
            cond_q[e] <= cond_upd[e];
        end
        if (acc0) begin
            data_q[tail]  <= enq_data[0 +: DW];
            cond_q[tail]  <= enq_cond_w[0];
            robid_q[tail] <= enq_robid[0 +: RW];
        end
        if (acc1) begin
            data_q[tail_p1]  <= enq_data[DW +: DW];
            cond_q[tail_p1]  <= enq_cond_w[1];
            robid_q[tail_p1] <= enq_robid[RW +: RW];
        end
    end

    // Surviving entries must form one run starting at head
    always_ff @(posedge clock) begin
        if (reset_n && flush_valid) begin
            assert (kill_ok) else $fatal(1, "isq_inorder_mw: non-contiguous flush kill pattern");
        end
    end

endmodule

// File: doc/isq_inorder_mw.md
ISQ_INORDER_MW -- requirements
Module: isq_inorder_mw

Interface
REQ-001 Parameter DEPTH, 8, entry count, power of two, >=4.
REQ-002 Parameter DEPTH_LOG, 3, log2(DEPTH).
REQ-003 Parameter DATA_WIDTH, 248, payload width.
REQ-004 Parameter COND_WIDTH, 2, wakeup condition bits per entry.
REQ-005 Parameter ROBID_WIDTH, 7, ROB id width including wrap bit (MSB).
REQ-006 Parameter NUM_WB, 2, number of writeback/update ports.
REQ-007 clock  input  1  clock; all state on rising edge.
REQ-008 reset_n  input  1  reset, asynchronous, active-low.
REQ-009 enq_valid  input  2  per-lane enqueue request; lane1 SHALL be asserted only with lane0.
REQ-010 enq_ready  output  1  common ready for both lanes.
REQ-011 enq_data  input  2*DATA_WIDTH  payloads, lane0 in LSBs.
REQ-012 enq_cond  input  2*COND_WIDTH  initial condition bits per lane.
REQ-013 enq_robid  input  2*ROBID_WIDTH  ROB id per lane.
REQ-014 deq_valid  output  1  head entry ready to issue.
REQ-015 deq_ready  input  1  consumer accepts head.
REQ-016 deq_data / deq_cond / deq_robid  output  DATA_WIDTH / COND_WIDTH / ROBID_WIDTH  head fields.
REQ-017 flush_valid  input  1  squash entries strictly younger than flush_robid.
REQ-018 flush_robid  input  ROBID_WIDTH  flush boundary id.
REQ-019 upd_valid / upd_robid / upd_mask / upd_data  input  NUM_WB / NUM_WB*ROBID_WIDTH / NUM_WB*COND_WIDTH / NUM_WB*COND_WIDTH  condition update ports.
REQ-020 count  output  DEPTH_LOG+1  occupied entries.

Function
REQ-021 Storage SHALL be a circular buffer with head/tail pointers of DEPTH_LOG bits wrapping modulo DEPTH; count ranges 0..DEPTH.
REQ-022 enq_ready SHALL equal (count <= DEPTH-2) and not flush_valid, independent of enq_valid.
REQ-023 Accepted lane0 SHALL write slot tail, lane1 slot tail+1; tail advances by popcount of accepted lanes.
REQ-024 An entry SHALL be ready when all condition bits are 1; deq_valid = (count!=0) and head ready.
REQ-025 Dequeue handshake (deq_valid & deq_ready) SHALL advance head by 1 and clear that slot's valid bit; data latency enqueue-to-deq_valid is minimum 1 cycle.
REQ-026 Simultaneous enqueue and dequeue SHALL update count = count + accepted - dequeued in one cycle.
REQ-027 For each port p and valid entry with robid == upd_robid[p], cond SHALL become (cond & ~mask) | (data & mask); multiple matching ports OR their effects, lower port winning on conflicting masked bits.
REQ-028 Entry e is younger than flush_robid iff (wrap bits differ) XOR (e.idx > flush.idx) over the low ROBID_WIDTH-1 bits.
REQ-029 On flush_valid all younger valid entries SHALL be invalidated, tail set to head+surviving count, count set to survivors; enqueue and dequeue blocked that cycle; updates still apply to survivors.
REQ-030 Flush with no younger entries SHALL leave state unchanged except blocked handshakes.
REQ-031 Survivors of a flush SHALL be contiguous from head; a non-contiguous kill pattern is a fatal assertion.

Reset
REQ-032 On reset_n low: head, tail, count = 0, all valid bits 0, deq_valid 0, enq_ready 1 after release; payload storage not reset.
REQ-033 Reset mid-operation SHALL discard all entries within the same cycle, asynchronously.

Configuration
REQ-034 Macro ISQ_UPD_BYPASS_EN: when defined, enq_cond of each lane SHALL be merged with same-cycle matching updates per REQ-027 before write; when undefined, same-cycle updates to entering entries are dropped and the producer SHALL redeliver.

Verification
REQ-035 Reset, enqueue 2 lanes robid 0,1 cond 2'b11 -> next cycle deq_valid=1, deq_robid=0, count=2.
REQ-036 Fill to count=7 -> enq_ready=0; dequeue one -> enq_ready=1 next cycle at count=6.
REQ-037 Head robid 5 cond 2'b01; upd port1 robid 5 mask 2'b10 data 2'b10 -> deq_valid rises next cycle.
REQ-038 Entries robid 62,63,64(wrap),65; flush_robid 63 -> survivors 62,63, count=2, tail=head+2.
REQ-039 Pointer wrap: 20 enqueue/dequeue pairs with DEPTH=8 -> outputs in robid order, no loss.
REQ-040 With ISQ_UPD_BYPASS_EN, enqueue robid 9 cond 2'b00 plus same-cycle update mask 2'b11 data 2'b11 -> deq_valid=1 next cycle; without macro -> deq_valid stays 0.
